// File: rtl/msd_pkg.sv
// Shared constants and helpers for the MSD multiplier scheduler.
// MSD digit codes: 2'b00 = -1, 2'b01 = 0, 2'b10 = +1.
package msd_pkg;

  localparam int unsigned MSD_MAX_DIGITS = 128;
  localparam int unsigned MSD_MAX_BITS   = 2 * MSD_MAX_DIGITS;

  localparam logic [1:0] MSD_ZERO_DIGIT = 2'b01;

  // Product width for a 2P-bit x 2Q-bit multiplier.
  function automatic int unsigned msd_prod_width(input int unsigned p, input int unsigned q);
    return 2 * p + 2 * q + 22;
  endfunction

  // n zero digits in the low 2n bits; callers slice the width they need.
  function automatic logic [MSD_MAX_BITS-1:0] msd_zero(input int unsigned n);
    logic [MSD_MAX_BITS-1:0] r;
    r = '0;
    for (int i = 0; i < int'(MSD_MAX_DIGITS); i++) begin
      if (i < int'(n)) begin
        r[2*i +: 2] = MSD_ZERO_DIGIT;
      end
    end
    return r;
  endfunction

  // Value of the low ndig digits; digits beyond bit 62 are ignored.
  function automatic longint msd_decode(input logic [MSD_MAX_BITS-1:0] v,
                                        input int unsigned ndig);
    longint r;
    r = 0;
    for (int i = 0; i < int'(MSD_MAX_DIGITS); i++) begin
      if (i < int'(ndig) && i < 63) begin
        if (v[2*i +: 2] == 2'b10) begin
          r = r + (longint'(1) <<< i);
        end else if (v[2*i +: 2] == 2'b00) begin
          r = r - (longint'(1) <<< i);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/msd_res_fifo.sv
// Result buffer: synchronous FIFO with output driven from storage, reads zero when empty.
module msd_res_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_wr, do_rd;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(DEPTH));
  assign count = count_q;

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr_q <= (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_rd) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifndef SYNTHESIS
  assert property (@(posedge clk) disable iff (!rst_n) !(wr_en && full))
    else $error("msd_res_fifo: write while full");
`endif

endmodule

// File: rtl/msd_mul_sched.sv
// Round-robin scheduler sharing one pipelined MSD multiplier among NREQ requesters,
// with tag tracking and credit-based protection of the result buffer.
module msd_mul_sched
  import msd_pkg::*;
#(
  parameter int unsigned P          = 33,
  parameter int unsigned Q          = 33,
  parameter int unsigned NREQ       = 4,
  parameter int unsigned LAT        = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NREQ-1:0]                   req_valid,
  output logic [NREQ-1:0]                   req_ready,
  input  logic [NREQ*2*P-1:0]               req_a,
  input  logic [NREQ*2*Q-1:0]               req_b,
  output logic [2*P-1:0]                    mul_a,
  output logic [2*Q-1:0]                    mul_b,
  input  logic [msd_prod_width(P, Q)-1:0]   mul_o,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic [$clog2(NREQ)-1:0]           res_id,
  output logic [msd_prod_width(P, Q)-1:0]   res_data,
  output logic                              busy
);

  localparam int unsigned IdW = $clog2(NREQ);
  localparam int unsigned PW  = msd_prod_width(P, Q);
  localparam int unsigned CrW = $clog2(FIFO_DEPTH + 1);

  localparam logic [MSD_MAX_BITS-1:0] ZeroAFull = msd_zero(P);
  localparam logic [MSD_MAX_BITS-1:0] ZeroBFull = msd_zero(Q);
  localparam logic [2*P-1:0]          ZeroA     = ZeroAFull[2*P-1:0];
  localparam logic [2*Q-1:0]          ZeroB     = ZeroBFull[2*Q-1:0];

  if (FIFO_DEPTH < LAT + 2) begin : gen_bad_depth
    $error("msd_mul_sched: FIFO_DEPTH must be >= LAT+2");
  end
  if (NREQ < 2) begin : gen_bad_nreq
    $error("msd_mul_sched: NREQ must be >= 2");
  end

  logic [IdW-1:0]        rr_ptr_q;
  logic [NREQ-1:0]       grant;
  logic [IdW-1:0]        gnt_id;
  logic [IdW-1:0]        arb_idx;
  logic                  found;
  logic                  can_issue;
  logic                  hs;
  logic                  pop;

  logic [2*P-1:0]        sel_a, mul_a_q;
  logic [2*Q-1:0]        sel_b, mul_b_q;

  logic [LAT:0]          tag_vld_q;
  logic [LAT:0][IdW-1:0] tag_id_q;

  logic [CrW-1:0]        credits_d, credits_q;

  logic                  fifo_empty, fifo_full;
  logic [CrW-1:0]        fifo_count;
  logic [IdW+PW-1:0]     fifo_rd_data;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    grant   = '0;
    gnt_id  = '0;
    arb_idx = '0;
    found   = 1'b0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      arb_idx = IdW'((int'(rr_ptr_q) + k) % int'(NREQ));
      if (!found && req_valid[arb_idx]) begin
        found          = 1'b1;
        grant[arb_idx] = 1'b1;
        gnt_id         = arb_idx;
      end
    end
  end

  assign can_issue = (credits_q < CrW'(FIFO_DEPTH));
  assign req_ready = can_issue ? grant : '0;
  assign hs        = can_issue && found;
  assign pop       = res_valid && res_ready;

  always_comb begin
    sel_a = ZeroA;
    sel_b = ZeroB;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (grant[i]) begin
        sel_a = req_a[i*2*P +: 2*P];
        sel_b = req_b[i*2*Q +: 2*Q];
      end
    end
  end

  // Idle cycles feed MSD zero so the multiplier never sees stale operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a_q  <= ZeroA;
      mul_b_q  <= ZeroB;
      rr_ptr_q <= IdW'(NREQ - 1);
    end else begin
      mul_a_q <= hs ? sel_a : ZeroA;
      mul_b_q <= hs ? sel_b : ZeroB;
      if (hs) begin
        rr_ptr_q <= gnt_id;
      end
    end
  end

  assign mul_a = mul_a_q;
  assign mul_b = mul_b_q;

  // Stage k lines up with the operands issued k+1 cycles ago; stage LAT meets mul_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_q <= '0;
      tag_id_q  <= '0;
    end else begin
      tag_vld_q <= {tag_vld_q[LAT-1:0], hs};
      tag_id_q  <= {tag_id_q[LAT-1:0], gnt_id};
    end
  end

  always_comb begin
    credits_d = credits_q;
    case ({hs, pop})
      2'b10:   credits_d = credits_q + CrW'(1);
      2'b01:   credits_d = credits_q - CrW'(1);
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits_q <= '0;
    end else begin
      credits_q <= credits_d;
    end
  end

  assign busy = (credits_q != '0);

  msd_res_fifo #(
    .WIDTH (IdW + PW),
    .DEPTH (FIFO_DEPTH)
  ) u_res_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (tag_vld_q[LAT]),
    .wr_data ({tag_id_q[LAT], mul_o}),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  assign res_valid = !fifo_empty;
  assign res_id    = fifo_rd_data[IdW+PW-1:PW];
  assign res_data  = fifo_rd_data[PW-1:0];

`ifndef SYNTHESIS
  assert property (@(posedge clk) disable iff (!rst_n) credits_q >= fifo_count)
    else $error("msd_mul_sched: credits below buffer occupancy");
  assert property (@(posedge clk) disable iff (!rst_n)
                   fifo_full |-> (credits_q == CrW'(FIFO_DEPTH)))
    else $error("msd_mul_sched: buffer full without all credits in use");
`endif

endmodule

// File: tb/tb_msd_mul_sched.sv
// Self-checking bench for msd_mul_sched with a behavioural LAT-cycle MSD multiplier.
module tb_msd_mul_sched;
  import msd_pkg::*;

  localparam int unsigned P          = 33;
  localparam int unsigned Q          = 33;
  localparam int unsigned NREQ       = 4;
  localparam int unsigned LAT        = 8;
  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned PW         = 2 * P + 2 * Q + 22;
  localparam int unsigned IdW        = 2;

  localparam logic [2*P-1:0] ZA = {P{2'b01}};
  localparam logic [2*Q-1:0] ZB = {Q{2'b01}};

  typedef struct {
    int     rid;
    longint a;
    longint b;
    longint prod;
  } vec_t;

  typedef struct {
    int     id;
    longint val;
  } exp_t;

  logic                clk;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*2*P-1:0] req_a;
  logic [NREQ*2*Q-1:0] req_b;
  logic [2*P-1:0]      mul_a;
  logic [2*Q-1:0]      mul_b;
  logic [PW-1:0]       mul_o;
  logic                res_valid;
  logic                res_ready;
  logic [IdW-1:0]      res_id;
  logic [PW-1:0]       res_data;
  logic                busy;

  int     n_chk = 0;
  int     n_fail = 0;
  int     hs_cnt = 0;
  longint va [NREQ];
  longint vb [NREQ];
  int     gnt_log [$];
  int     res_log [$];
  exp_t   sb [$];
  int     mon_id;
  exp_t   mon_e;

  msd_mul_sched #(
    .P          (P),
    .Q          (Q),
    .NREQ       (NREQ),
    .LAT        (LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_o     (mul_o),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_data  (res_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] msd_encode(input longint v, input int unsigned ndig);
    logic [255:0] r;
    longint       m;
    logic         b;
    r = '0;
    m = (v < 0) ? -v : v;
    for (int i = 0; i < 128; i++) begin
      if (i < int'(ndig)) begin
        b = (i < 63) ? m[i] : 1'b0;
        if (v < 0) r[2*i +: 2] = b ? 2'b00 : 2'b01;
        else       r[2*i +: 2] = b ? 2'b10 : 2'b01;
      end
    end
    return r;
  endfunction

  // Multiplier model: not reset, so stale products keep flowing after a reset.
  logic [255:0]  pe_full;
  logic [PW-1:0] pipe [LAT];
  always_comb pe_full = msd_encode(msd_decode(256'(mul_a), P) * msd_decode(256'(mul_b), Q),
                                   PW / 2);
  always @(posedge clk) begin
    pipe[0] <= pe_full[PW-1:0];
    for (int k = 1; k < int'(LAT); k++) pipe[k] <= pipe[k-1];
  end
  assign mul_o = pipe[LAT-1];

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_vec(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_op(input int i, input longint a, input longint b);
    logic [255:0] ea, eb;
    va[i] = a;
    vb[i] = b;
    ea = msd_encode(a, P);
    eb = msd_encode(b, Q);
    req_a[i*2*P +: 2*P] = ea[2*P-1:0];
    req_b[i*2*Q +: 2*Q] = eb[2*Q-1:0];
  endtask

  task automatic wait_idle(input int bound);
    int c;
    c = 0;
    while (busy && c < bound) begin
      @(negedge clk);
      c++;
    end
    check("drain_idle", busy, 0);
  endtask

  // Scoreboard: push on handshake, pop and compare on result pop.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (|(req_valid & req_ready)) begin
        check("ready_onehot", $countones(req_ready), 1);
        mon_id = 0;
        for (int i = 0; i < int'(NREQ); i++) if (req_ready[i]) mon_id = i;
        hs_cnt++;
        gnt_log.push_back(mon_id);
        mon_e.id  = mon_id;
        mon_e.val = va[mon_id] * vb[mon_id];
        sb.push_back(mon_e);
      end
      if (res_valid && res_ready) begin
        res_log.push_back(int'(res_id));
        check("sb_has_entry", (sb.size() > 0), 1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          check("sb_res_id", res_id, mon_e.id);
          check("sb_res_data", msd_decode(256'(res_data), PW / 2), mon_e.val);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  vec_t vecs [4];
  int   got, lat, h0, h1, h2, g0, r0;

  initial begin
    vecs[0] = '{rid: 2, a: 3,    b: 5,   prod: 15};
    vecs[1] = '{rid: 0, a: -7,   b: 6,   prod: -42};
    vecs[2] = '{rid: 1, a: 1000, b: -3,  prod: -3000};
    vecs[3] = '{rid: 3, a: -12,  b: -11, prod: 132};

    rst_n     = 1'b0;
    req_valid = '0;
    res_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < int'(NREQ); i++) set_op(i, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 0);
    check_vec("rst_mul_a", 256'(mul_a), 256'(ZA));
    check_vec("rst_mul_b", 256'(mul_b), 256'(ZB));
    check("rst_res_valid", res_valid, 0);
    check("rst_res_id", res_id, 0);
    check_vec("rst_res_data", 256'(res_data), '0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;

    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check_vec("idle_mul_a", 256'(mul_a), 256'(ZA));
      check_vec("idle_mul_b", 256'(mul_b), 256'(ZB));
    end

    // Single operations from the vector table.
    for (int v = 0; v < 4; v++) begin
      @(posedge clk); #1;
      set_op(vecs[v].rid, vecs[v].a, vecs[v].b);
      req_valid = '0;
      req_valid[vecs[v].rid] = 1'b1;
      got = 0;
      for (int c = 0; c < 20 && got == 0; c++) begin
        @(negedge clk);
        if (req_ready[vecs[v].rid]) got = 1;
        else begin @(posedge clk); #1; end
      end
      check("vec_handshake", got, 1);
      @(posedge clk); #1;
      req_valid = '0;
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!res_valid && lat < 40);
      check("vec_latency", lat, LAT + 2);
      check("vec_res_id", res_id, vecs[v].rid);
      check("vec_res_data", msd_decode(256'(res_data), PW / 2), vecs[v].prod);
      check("vec_busy_at_pop", busy, 1);
      @(negedge clk);
      check("vec_busy_after_pop", busy, 0);
      check("vec_res_valid_after_pop", res_valid, 0);
    end

    // Fairness: all requesters valid for 8 grants.
    @(posedge clk); #1;
    for (int i = 0; i < int'(NREQ); i++) set_op(i, i + 2, -(i + 5));
    req_valid = '1;
    h0 = hs_cnt;
    g0 = gnt_log.size();
    r0 = res_log.size();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (hs_cnt - h0 >= 8) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle(60);
    check("fair_grant_count", gnt_log.size() - g0, 8);
    check("fair_result_count", res_log.size() - r0, 8);
    for (int k = 0; k < 8; k++) begin
      if (g0 + k < gnt_log.size()) check("fair_grant_order", gnt_log[g0+k], k % 4);
      if (r0 + k < res_log.size()) check("fair_result_order", res_log[r0+k], k % 4);
    end

    // Credit limit with the consumer stalled.
    @(posedge clk); #1;
    res_ready = 1'b0;
    req_valid = '1;
    h0 = hs_cnt;
    repeat (30) begin @(posedge clk); #1; end
    check("limit_handshakes", hs_cnt - h0, FIFO_DEPTH);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("limit_ready_low", req_ready, 0);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(negedge clk);
    check("pop_cycle_no_issue", req_ready, 0);
    check("pop_cycle_valid", res_valid, 1);
    @(posedge clk); #1;
    res_ready = 1'b0;
    h1 = hs_cnt;
    @(negedge clk);
    check("issue_after_pop", |req_ready, 1);
    repeat (5) begin @(posedge clk); #1; end
    check("one_extra_issue", hs_cnt - h1, 1);

    // Same-cycle issue and pop at 15 credits.
    req_valid = '0;
    res_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    req_valid = '1;
    h2 = hs_cnt;
    @(negedge clk);
    check("same_cycle_ready", |req_ready, 1);
    check("same_cycle_pop", res_valid, 1);
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(negedge clk);
    check("credits_held_grant", |req_ready, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("full_after_issue", req_ready, 0);
    @(posedge clk); #1;
    req_valid = '0;
    check("same_cycle_handshakes", hs_cnt - h2, 2);
    res_ready = 1'b1;
    wait_idle(100);
    check("scoreboard_empty", sb.size(), 0);

    // Reset with 5 in flight and 3 buffered.
    @(posedge clk); #1;
    res_ready = 1'b0;
    req_valid = '1;
    h0 = hs_cnt;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (hs_cnt - h0 >= 8) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    req_valid = '0;
    repeat (4) begin @(posedge clk); #1; end
    check("pre_reset_busy", busy, 1);
    check("pre_reset_res_valid", res_valid, 1);
    rst_n = 1'b0;
    #2;
    check("mid_rst_req_ready", req_ready, 0);
    check_vec("mid_rst_mul_a", 256'(mul_a), 256'(ZA));
    check_vec("mid_rst_mul_b", 256'(mul_b), 256'(ZB));
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_res_id", res_id, 0);
    check_vec("mid_rst_res_data", 256'(res_data), '0);
    check("mid_rst_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    res_ready = 1'b1;
    for (int c = 0; c < int'(2 * LAT); c++) begin
      @(negedge clk);
      check("post_reset_res_valid", res_valid, 0);
      check("post_reset_busy", busy, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
